// File: rtl/ser_xmtr.sv
// ser_xmtr: parallel-to-serial frame transmitter.
// 16-bit words enter a small FIFO through a valid/ready handshake and leave
// MSB first on a three-wire link (o_sclk, o_fs, o_d) as back-to-back frames.
// Handshake: a word is taken on a rising i_clk edge when i_vld & o_rdy are
// both high; i_data must be stable while i_vld is high; o_rdy depends only
// on registered occupancy, never on i_vld.
// A single lead-in slot follows reset so the receiver's bit counter lines up
// with the first real word. Internal FSM state is in the signal 'state'.
module ser_xmtr #(
  parameter int          HALF_DIV   = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
  input  logic                          i_clk,
  input  logic                          rst,
  input  logic [15:0]                   i_data,
  input  logic                          i_vld,
  output logic                          o_rdy,
  output logic                          o_sclk,
  output logic                          o_fs,
  output logic                          o_d,
  output logic                          o_underrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int DW = $clog2(HALF_DIV) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    LEAD  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_idx;
  logic [15:0]   shreg;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          tick;
  logic          rise;
  logic          load;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [15:0]   load_word;

  // tick ends a half period; a rise event is a tick while sclk is still low
  assign tick       = (div_cnt == DIV_LAST);
  assign rise       = tick & ~o_sclk;
  assign fifo_empty = (o_level == '0);
  assign o_rdy      = (o_level != LVL_FULL);
  assign push       = i_vld & o_rdy;
  // a word is loaded at START and after the LSB slot of every frame
  assign load       = rise & ((state == START) | ((state == SHIFT) && (bit_idx == 4'd0)));
  // no bypass: an empty FIFO sends IDLE_WORD even if a write lands now
  assign pop        = load & ~fifo_empty;
  assign load_word  = fifo_empty ? IDLE_WORD : mem[rd_ptr];

  // serial clock divider: toggle o_sclk every HALF_DIV system clocks
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      o_sclk  <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      o_sclk  <= ~o_sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   o_level <= o_level + LW'(1);
        2'b01:   o_level <= o_level - LW'(1);
        default: o_level <= o_level;
      endcase
    end
  end

  // framing FSM: advances and updates o_d/o_fs only on rise events
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state      <= LEAD;
      bit_idx    <= 4'd0;
      shreg      <= 16'h0000;
      o_d        <= 1'b0;
      o_fs       <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      if (rise) begin
        unique case (state)
          LEAD: begin
            o_d   <= 1'b0;
            o_fs  <= 1'b0;
            state <= START;
          end
          START: begin
            shreg      <= load_word;
            o_d        <= load_word[15];
            o_fs       <= 1'b0;
            bit_idx    <= 4'd15;
            o_underrun <= fifo_empty;
            state      <= SHIFT;
          end
          SHIFT: begin
            if (bit_idx == 4'd0) begin
              shreg      <= load_word;
              o_d        <= load_word[15];
              o_fs       <= 1'b0;
              bit_idx    <= 4'd15;
              o_underrun <= fifo_empty;
            end else if (bit_idx == 4'd1) begin
              o_d     <= shreg[0];
              o_fs    <= 1'b1;
              bit_idx <= 4'd0;
            end else begin
              o_d     <= shreg[bit_idx - 4'd1];
              o_fs    <= 1'b0;
              bit_idx <= bit_idx - 4'd1;
            end
          end
          default: state <= LEAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ser_xmtr.sv
// tb_ser_xmtr: directed bench for ser_xmtr with HALF_DIV=2 (dut_a) and
// HALF_DIV=1 (dut_b). Monitors capture every serial slot and decode frames
// using o_fs, like the downstream receiver.
module tb_ser_xmtr;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic        rst_a, rst_b;
  logic [15:0] i_data_a, i_data_b;
  logic        i_vld_a, i_vld_b;
  logic        o_rdy_a, o_sclk_a, o_fs_a, o_d_a, o_underrun_a;
  logic        o_rdy_b, o_sclk_b, o_fs_b, o_d_b, o_underrun_b;
  logic [2:0]  o_level_a, o_level_b;

  ser_xmtr #(.HALF_DIV(2), .FIFO_DEPTH(4), .IDLE_WORD(16'h0000)) dut_a (
    .i_clk(i_clk), .rst(rst_a), .i_data(i_data_a), .i_vld(i_vld_a),
    .o_rdy(o_rdy_a), .o_sclk(o_sclk_a), .o_fs(o_fs_a), .o_d(o_d_a),
    .o_underrun(o_underrun_a), .o_level(o_level_a)
  );

  ser_xmtr #(.HALF_DIV(1), .FIFO_DEPTH(4), .IDLE_WORD(16'h0000)) dut_b (
    .i_clk(i_clk), .rst(rst_b), .i_data(i_data_b), .i_vld(i_vld_b),
    .o_rdy(o_rdy_b), .o_sclk(o_sclk_b), .o_fs(o_fs_b), .o_d(o_d_b),
    .o_underrun(o_underrun_b), .o_level(o_level_b)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---------------- slot monitors / receiver models ----------------
  logic [1:0]  slot_a_q[$];
  int          slot_a_t[$];
  logic [15:0] rx_a_q[$];
  int          und_a = 0;
  logic        prev_a = 1'b0;
  logic [15:0] sh_a = 16'h0;

  always @(negedge i_clk) begin
    if (rst_a) begin
      prev_a = 1'b0;
      sh_a   = 16'h0;
    end else begin
      if (o_underrun_a) und_a++;
      if (o_sclk_a && !prev_a) begin
        slot_a_q.push_back({o_d_a, o_fs_a});
        slot_a_t.push_back(cyc);
        sh_a = {sh_a[14:0], o_d_a};
        if (o_fs_a) rx_a_q.push_back(sh_a);
      end
      prev_a = o_sclk_a;
    end
  end

  logic [1:0]  slot_b_q[$];
  int          slot_b_t[$];
  logic [15:0] rx_b_q[$];
  int          und_b = 0;
  logic        prev_b = 1'b0;
  logic [15:0] sh_b = 16'h0;

  always @(negedge i_clk) begin
    if (rst_b) begin
      prev_b = 1'b0;
      sh_b   = 16'h0;
    end else begin
      if (o_underrun_b) und_b++;
      if (o_sclk_b && !prev_b) begin
        slot_b_q.push_back({o_d_b, o_fs_b});
        slot_b_t.push_back(cyc);
        sh_b = {sh_b[14:0], o_d_b};
        if (o_fs_b) rx_b_q.push_back(sh_b);
      end
      prev_b = o_sclk_b;
    end
  end

  // {data bits, fs bits} of 16 slots starting at base, first slot in MSB
  function automatic logic [31:0] frame_bits(input logic [1:0] q[$], input int base);
    logic [15:0] d;
    logic [15:0] fs;
    logic [1:0]  s;
    d  = 16'h0;
    fs = 16'h0;
    for (int i = 0; i < 16; i++) begin
      s  = q[base + i];
      d  = {d[14:0], s[1]};
      fs = {fs[14:0], s[0]};
    end
    return {d, fs};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_a(input logic [15:0] w);
    i_data_a = w;
    i_vld_a  = 1'b1;
    @(posedge i_clk);
    #1;
    i_vld_a  = 1'b0;
  endtask

  task automatic wait_a(input int n, input string tag);
    int t = 0;
    while (slot_a_q.size() < n && t < 3000) begin
      @(posedge i_clk);
      t++;
    end
    #1;
    chk(tag, 32'(slot_a_q.size() >= n), 32'd1);
  endtask

  task automatic wait_b(input int n, input string tag);
    int t = 0;
    while (slot_b_q.size() < n && t < 3000) begin
      @(posedge i_clk);
      t++;
    end
    #1;
    chk(tag, 32'(slot_b_q.size() >= n), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  s;
    logic [15:0] next_w;
    logic        rdy_s;
    logic        saw_full;
    logic        s0;
    int          rdy_bad, accepted, k, bad, t, base;

    rst_a = 1'b1; rst_b = 1'b1;
    i_vld_a = 1'b0; i_vld_b = 1'b0;
    i_data_a = 16'h0; i_data_b = 16'h0;
    repeat (3) @(posedge i_clk);
    #1;

    // reset state
    chk("rst_sclk",  32'(o_sclk_a), 32'd0);
    chk("rst_d",     32'(o_d_a), 32'd0);
    chk("rst_fs",    32'(o_fs_a), 32'd0);
    chk("rst_und",   32'(o_underrun_a), 32'd0);
    chk("rst_level", 32'(o_level_a), 32'd0);
    chk("rst_rdy",   32'(o_rdy_a), 32'd1);

    // lead-in, then A5C3, then 1234/FFFF back to back
    rst_a = 1'b0;
    wait_a(1, "wait_lead");
    s = slot_a_q[0];
    chk("lead_slot", 32'(s), 32'd0);
    write_a(16'hA5C3);
    chk("level_1", 32'(o_level_a), 32'd1);
    wait_a(2, "wait_first");
    write_a(16'h1234);
    write_a(16'hFFFF);
    chk("level_2", 32'(o_level_a), 32'd2);
    wait_a(49, "wait_3frames");
    chk("sclk_period", 32'(slot_a_t[2] - slot_a_t[1]), 32'd4);
    chk("frm_a5c3", frame_bits(slot_a_q, 1),  {16'hA5C3, 16'h0001});
    chk("frm_1234", frame_bits(slot_a_q, 17), {16'h1234, 16'h0001});
    chk("frm_ffff", frame_bits(slot_a_q, 33), {16'hFFFF, 16'h0001});
    chk("rx_cnt3",  32'(rx_a_q.size()), 32'd3);
    chk("rx0", 32'(rx_a_q[0]), 32'h0000A5C3);
    chk("rx1", 32'(rx_a_q[1]), 32'h00001234);
    chk("rx2", 32'(rx_a_q[2]), 32'h0000FFFF);
    chk("no_underrun", 32'(und_a), 32'd0);

    // drained: idle frame with one underrun pulse
    wait_a(65, "wait_idle");
    chk("frm_idle", frame_bits(slot_a_q, 49), {16'h0000, 16'h0001});
    chk("underrun_1", 32'(und_a), 32'd1);
    chk("level_0", 32'(o_level_a), 32'd0);

    // hold i_vld with incrementing data: back-pressure, no loss/duplication
    rx_a_q.delete();
    next_w = 16'h0100; accepted = 0; rdy_bad = 0; saw_full = 1'b0;
    for (int c = 0; c < 700; c++) begin
      i_data_a = next_w;
      i_vld_a  = 1'b1;
      rdy_s    = o_rdy_a;
      if (o_level_a == 3'd4) saw_full = 1'b1;
      if (o_rdy_a != (o_level_a != 3'd4)) rdy_bad++;
      @(posedge i_clk);
      #1;
      if (rdy_s) begin
        accepted++;
        next_w = next_w + 16'd1;
      end
    end
    i_vld_a = 1'b0;
    chk("saw_full", 32'(saw_full), 32'd1);
    chk("rdy_vs_level", 32'(rdy_bad), 32'd0);
    chk("accept_rate", 32'(accepted >= 13 && accepted <= 15), 32'd1);
    t = 0;
    while (o_level_a != 3'd0 && t < 2000) begin
      @(posedge i_clk);
      t++;
    end
    #1;
    chk("drain", 32'(o_level_a), 32'd0);
    repeat (100) @(posedge i_clk);
    #1;
    k = 0; bad = 0;
    foreach (rx_a_q[i]) begin
      if (rx_a_q[i] != 16'h0000) begin
        if (rx_a_q[i] != 16'(16'h0100 + k)) bad++;
        k++;
      end
    end
    chk("stream_count", 32'(k), 32'(accepted));
    chk("stream_order", 32'(bad), 32'd0);

    // reset in the middle of a word (bit_idx=7)
    base = slot_a_q.size();
    t = 0;
    while (t < 3000) begin
      if (slot_a_q.size() > base) begin
        s = slot_a_q[slot_a_q.size() - 1];
        if (s[0]) break;
      end
      @(posedge i_clk);
      t++;
    end
    #1;
    chk("wait_fs", 32'(t < 3000), 32'd1);
    write_a(16'hBEEF);
    write_a(16'h1111);
    base = slot_a_q.size();
    wait_a(base + 9, "wait_bit7");
    s = slot_a_q[slot_a_q.size() - 1];
    chk("bit7_slot", 32'(s), 32'd2);
    chk("pre_rst_d", 32'(o_d_a), 32'd1);
    chk("pre_rst_level", 32'(o_level_a), 32'd1);
    rst_a = 1'b1;
    #1;
    chk("mid_rst_d",     32'(o_d_a), 32'd0);
    chk("mid_rst_fs",    32'(o_fs_a), 32'd0);
    chk("mid_rst_sclk",  32'(o_sclk_a), 32'd0);
    chk("mid_rst_level", 32'(o_level_a), 32'd0);
    chk("mid_rst_rdy",   32'(o_rdy_a), 32'd1);
    @(posedge i_clk);
    #1;
    slot_a_q.delete();
    slot_a_t.delete();
    rx_a_q.delete();
    rst_a = 1'b0;
    write_a(16'h5AA5);
    wait_a(17, "wait_relead");
    s = slot_a_q[0];
    chk("relead_slot", 32'(s), 32'd0);
    chk("frm_5aa5", frame_bits(slot_a_q, 1), {16'h5AA5, 16'h0001});
    chk("rerx_cnt", 32'(rx_a_q.size()), 32'd1);
    chk("rerx0", 32'(rx_a_q[0]), 32'h00005AA5);

    // HALF_DIV=1: sclk toggles every clock, 0x8001 frame
    i_data_b = 16'h8001;
    i_vld_b  = 1'b1;
    @(posedge i_clk);
    #1;
    rst_b = 1'b0;
    @(posedge i_clk);
    #1;
    i_vld_b = 1'b0;
    chk("b_level_1", 32'(o_level_b), 32'd1);
    s0 = o_sclk_b;
    @(posedge i_clk);
    #1;
    chk("b_toggle", 32'(o_sclk_b != s0), 32'd1);
    wait_b(17, "b_wait_frame");
    s = slot_b_q[0];
    chk("b_lead_slot", 32'(s), 32'd0);
    chk("b_period", 32'(slot_b_t[2] - slot_b_t[1]), 32'd2);
    chk("b_frm_8001", frame_bits(slot_b_q, 1), {16'h8001, 16'h0001});
    chk("b_rx0", 32'(rx_b_q[0]), 32'h00008001);
    chk("b_no_underrun", 32'(und_b), 32'd0);
    wait_b(18, "b_wait_idle");
    chk("b_underrun_1", 32'(und_b), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ser_xmtr.md
Name: ser_xmtr

Overview:
Parallel-to-serial frame transmitter that drives the three-wire serial link (frame sync, serial clock, data) consumed by the downstream 16-bit serial receiver.
- Accepts 16-bit words through a valid/ready handshake into a small FIFO.
- Generates the serial clock by dividing the system clock.
- Shifts each word out MSB first as continuous back-to-back 16-bit frames.
- Inserts a one-slot lead-in after reset so the receiver's bit counter aligns on the first word.

Parameters:
HALF_DIV, 2, system clocks per serial-clock half period (>=1); sclk period = 2*HALF_DIV clocks.
FIFO_DEPTH, 4, input FIFO depth in words; power of 2, >=2.
IDLE_WORD, 16'h0000, word transmitted when the FIFO is empty at a word boundary.

Ports:
i_clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
i_data  in  16  word to transmit.
i_vld  in  1  i_data valid.
o_rdy  out  1  FIFO not full; a word is accepted when i_vld & o_rdy.
o_sclk  out  1  serial clock to the receiver.
o_fs  out  1  frame sync: high during the last bit (LSB) of every word.
o_d  out  1  serial data, MSB first.
o_underrun  out  1  one-clock pulse when IDLE_WORD is substituted.
o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, active-high):
  - o_sclk=0, o_d=0, o_fs=0, o_underrun=0.
  - FIFO empty: o_level=0, o_rdy=1.
  - Divider counter=0; state=LEAD.
- Divider:
  - div_cnt counts 0..HALF_DIV-1; o_sclk toggles when div_cnt==HALF_DIV-1, then div_cnt wraps to 0.
  - A "rise event" is the clock on which o_sclk toggles 0->1.
  - o_d and o_fs change only on rise events, registered in that same clock, so they are stable at the receiver's sampling (falling) edge.
- State machine (advances on rise events only):
  - LEAD: first rise event after reset; o_d=0, o_fs=0; next state START.
  - START: second rise event; load word W0; o_d=W0[15], o_fs=0, bit_idx=15; next state SHIFT.
  - SHIFT:
    - bit_idx>1: bit_idx-1, o_d=next bit, o_fs=0.
    - bit_idx==1: o_d=bit 0, o_fs=1, bit_idx=0.
    - bit_idx==0: load the next word; o_d=new[15], o_fs=0, bit_idx=15.
- Framing: exactly 16 slots per word, no gaps. o_fs high for exactly one sclk period per word, coinciding with the LSB.
- Word load: on a load event, pop the FIFO head if o_level>0.
  - If the FIFO is empty, transmit IDLE_WORD and pulse o_underrun for that single clock.
  - There is no bypass: a write in the same clock as a load into an empty FIFO is not used for that load.
- FIFO:
  - Circular buffer with a separate occupancy count.
  - Simultaneous push and pop leaves o_level unchanged.
  - o_rdy = (o_level != FIFO_DEPTH), derived combinationally from the registered level.
  - Writes while full are ignored (o_rdy=0).
- Reset mid-operation: outputs are forced to reset values immediately and queued words are discarded. The sequence restarts with LEAD so the receiver realigns.
- Width rule: bit_idx is 4 bits; div_cnt is sized $clog2(HALF_DIV)+1.

Test Plan:
- Reset, HALF_DIV=2, no writes -> o_sclk period 4 clocks; slot 1 o_d=0/o_fs=0; then IDLE_WORD frames with o_underrun pulsing once per 16 sclk periods; o_fs high on every 16th slot.
- Write 16'hA5C3 before the second rise event -> o_d at successive rise events = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; o_fs=1 only on the last; loopback receiver outputs o_vld with o_data=16'hA5C3.
- Write 16'h1234 and 16'hFFFF back-to-back -> 32 contiguous slots, o_fs high on slots 16 and 32; receiver yields 0x1234 then 0xFFFF; o_underrun=0 until the FIFO drains.
- Hold i_vld=1 with incrementing data, FIFO_DEPTH=4 -> o_rdy drops when o_level=4; exactly one word accepted per 16 sclk periods afterwards; no word lost or duplicated.
- HALF_DIV=1 -> o_sclk toggles every clock; frame timing and loopback data (0x8001) still correct.
- Assert rst for 1 clock mid-word (bit_idx=7) -> o_d/o_fs/o_sclk=0 immediately; FIFO empty; next frame preceded by a lead-in slot; receiver reset in parallel decodes the next word correctly.
